mem_port_arbiter: RTL

- Sequences and shares one single-ported, fixed-latency unified memory between the fetch stage (instruction reads) and the memory stage (data reads/writes).
- Accepts one request at a time and holds the memory command stable for LAT cycles.
- Returns a one-cycle done strobe with read data, and generates per-requester stall signals for pipeline control.
- Sits between fetch/memory stages and the shared memory instance.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-port fixed-latency memory shared by fetch (IF) and data (DM) stages
// Optional build macro ARB_FAIR_EN: alternate contended grants between IF and DM instead of fixed DM priority.
module mem_port_arbiter #(
    parameter int LAT = 4,
    parameter int AW  = 16,
    parameter int DW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    output logic          if_err,
    input  logic          dm_req,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_stall,
    output logic          dm_err,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY_IF = 3'd1,
        BUSY_DM = 3'd2,
        ERR_IF  = 3'd3,
        ERR_DM  = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          lat_wr;
    logic          grant_dm;
    logic          accept;
    logic [AW-1:0] sel_addr;

`ifdef ARB_FAIR_EN
    logic last_dm;

    // Remember who won the last contended grant so the other side wins next time.
    always_ff @(posedge clk) begin
        if (rst)
            last_dm <= 1'b0;
        else if (accept && if_req && dm_req)
            last_dm <= grant_dm;
    end

    // Contended requests go to whoever lost last time; uncontended go to the sole requester.
    always_comb begin
        grant_dm = dm_req;
        if (if_req && dm_req)
            grant_dm = ~last_dm;
    end
`else
    // DM has fixed priority over IF.
    always_comb begin
        grant_dm = dm_req;
    end
`endif

    assign accept   = (state == IDLE) && (if_req || dm_req);
    assign sel_addr = grant_dm ? dm_addr : if_addr;
    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

    // State, latency counter and the request snapshot that drives memory during the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wr    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_addr  <= sel_addr;
                lat_wdata <= grant_dm ? dm_wdata : '0;
                lat_wr    <= grant_dm & dm_wr;
            end
        end
    end

    // Next state and all outputs; memory command is held from the snapshot while busy.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_done   = 1'b0;
        if_rdata  = '0;
        if_err    = 1'b0;
        dm_done   = 1'b0;
        dm_rdata  = '0;
        dm_err    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_addr[0])
                        state_nxt = grant_dm ? ERR_DM : ERR_IF;
                    else begin
                        state_nxt = grant_dm ? BUSY_DM : BUSY_IF;
                        cnt_nxt   = 4'(LAT - 1);
                    end
                end
            end
            BUSY_IF: begin
                mem_en   = 1'b1;
                mem_addr = lat_addr;
                if (cnt == 4'd0) begin
                    if_done   = 1'b1;
                    if_rdata  = mem_rdata;
                    state_nxt = IDLE;
                end else
                    cnt_nxt = cnt - 4'd1;
            end
            BUSY_DM: begin
                mem_en    = 1'b1;
                mem_wr    = lat_wr;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                if (cnt == 4'd0) begin
                    dm_done   = 1'b1;
                    dm_rdata  = lat_wr ? '0 : mem_rdata;
                    state_nxt = IDLE;
                end else
                    cnt_nxt = cnt - 4'd1;
            end
            ERR_IF: begin
                if_done   = 1'b1;
                if_err    = 1'b1;
                state_nxt = IDLE;
            end
            ERR_DM: begin
                dm_done   = 1'b1;
                dm_err    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

endmodule
